// File: rtl/axi_oq_word_packer.sv
// AXI-Stream to word FIFO packer with per-packet destination tagging.
// Drops packets with no destination and reports per-packet byte length.
module axi_oq_word_packer #(
  parameter int TDATA_BYTES     = 32,
  parameter int TUSER_WIDTH     = 128,
  parameter int NUM_QUEUES      = 5,
  parameter int DST_OFFSET      = 24,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DROP_NO_DST     = 1,
  localparam int CW = $clog2(TDATA_BYTES) + 1,
  localparam int DW = 8 * TDATA_BYTES,
  localparam int WW = DW + CW + 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tvalid,
  output logic                   tready,
  input  logic [DW-1:0]          tdata,
  input  logic [TDATA_BYTES-1:0] tstrb,
  input  logic [TUSER_WIDTH-1:0] tuser,
  input  logic                   tlast,
  output logic [WW-1:0]          dout,
  output logic                   dout_valid,
  input  logic                   dout_rd,
  output logic [NUM_QUEUES-1:0]  oq,
  output logic [15:0]            pkt_len,
  output logic                   pkt_len_valid,
  output logic [15:0]            drop_cnt
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WW-1:0]         r_mem     [DEPTH];
  logic [NUM_QUEUES-1:0] r_dst_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_fill;
  logic [AW:0]           w_fill_nxt;
  logic                  r_full;

  logic [15:0]           r_run;
  logic [15:0]           r_pkt_len;
  logic                  r_len_vld;
  logic [15:0]           r_drop_cnt;
  logic [NUM_QUEUES-1:0] r_dst;

  logic [NUM_QUEUES-1:0] w_dst_in;
  logic [NUM_QUEUES-1:0] w_dst_wr;
  logic [CW-1:0]         w_cnt;
  logic [16:0]           w_base;
  logic [16:0]           w_sum;
  logic [15:0]           w_total;
  logic                  w_acc;
  logic                  w_push;
  logic                  w_wr;
  logic                  w_pop;
  logic                  w_sop;
  logic                  w_eop;
  logic                  w_drop_sop;
  logic                  w_no_dst;
  logic                  w_unused;

  assign w_unused = ^tuser;

  assign w_dst_in = tuser[DST_OFFSET +: NUM_QUEUES];
  assign w_no_dst = (w_dst_in == '0) && (DROP_NO_DST != 0);
  assign w_dst_wr = (r_state == S_IDLE) ? w_dst_in : r_dst;

  // tready never looks at tvalid; full is registered
  assign tready = !reset && (!r_full || r_state == S_DROP);
  assign w_acc  = tvalid && tready;

  // Bytes in this beat: set strobe bits, contiguous or not
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < TDATA_BYTES; i++) begin
      w_cnt = w_cnt + CW'(tstrb[i]);
    end
  end

  // Packet byte total including this beat, saturating at 16 bits
  always_comb begin
    w_base  = (r_state == S_IDLE) ? 17'd0 : {1'b0, r_run};
    w_sum   = w_base + 17'(w_cnt);
    w_total = w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc && !tlast) begin
          w_next = w_no_dst ? S_DROP : S_PKT;
        end
      end
      S_PKT: begin
        if (w_acc && tlast) begin
          w_next = S_IDLE;
        end
      end
      S_DROP: begin
        if (w_acc && tlast) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Per-beat write, framing and drop decisions
  always_comb begin
    w_push     = 1'b0;
    w_sop      = 1'b0;
    w_eop      = 1'b0;
    w_drop_sop = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_sop      = 1'b1;
        w_eop      = tlast;
        w_push     = w_acc && !w_no_dst;
        w_drop_sop = w_acc && w_no_dst;
      end
      S_PKT: begin
        w_eop  = tlast;
        w_push = w_acc;
      end
      S_DROP: begin
        w_push = 1'b0;
      end
      default: begin
        w_push = 1'b0;
      end
    endcase
  end

  // Read and write qualifiers; a write into a full FIFO needs a read
  assign dout_valid = (r_fill != '0);
  assign w_pop      = dout_rd && dout_valid;
  assign w_wr       = w_push && (!r_full || w_pop);
  assign w_fill_nxt = r_fill + (AW+1)'(w_wr) - (AW+1)'(w_pop);

  // Packet length, drop counter and current destination
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run      <= '0;
      r_pkt_len  <= '0;
      r_len_vld  <= 1'b0;
      r_drop_cnt <= '0;
      r_dst      <= '0;
    end else begin
      r_len_vld <= 1'b0;
      if (w_wr) begin
        r_run <= w_eop ? 16'd0 : w_total;
        if (w_eop) begin
          r_pkt_len <= w_total;
          r_len_vld <= 1'b1;
        end
      end
      if (w_acc && r_state == S_IDLE) begin
        r_dst <= w_dst_in;
      end
      if (w_drop_sop && r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_fill <= w_fill_nxt;
      r_full <= (w_fill_nxt == (AW+1)'(DEPTH));
    end
  end

  // FIFO storage: packed word plus its destination mask
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr]     <= {w_eop, w_sop, w_cnt, tdata};
      r_dst_mem[r_wptr] <= w_dst_wr;
    end
  end

  assign dout          = dout_valid ? r_mem[r_rptr] : '0;
  assign oq            = dout_valid ? r_dst_mem[r_rptr] : '0;
  assign pkt_len       = r_pkt_len;
  assign pkt_len_valid = r_len_vld;
  assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_axi_oq_word_packer.sv
// Bench for axi_oq_word_packer: strobe table, directed corner
// sequences and random packets against a packet-level model.
module tb_axi_oq_word_packer;

  localparam int TB = 32;
  localparam int TW = 128;
  localparam int NQ = 5;
  localparam int DO = 24;
  localparam int FL = 4;
  localparam int CW = $clog2(TB) + 1;
  localparam int DW = 8 * TB;
  localparam int WW = DW + CW + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [TB-1:0] tstrb;
  logic [TW-1:0] tuser;
  logic          tlast;
  logic [WW-1:0] dout;
  logic          dout_valid;
  logic          dout_rd;
  logic [NQ-1:0] oq;
  logic [15:0]   pkt_len;
  logic          pkt_len_valid;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  axi_oq_word_packer #(
    .TDATA_BYTES(TB),
    .TUSER_WIDTH(TW),
    .NUM_QUEUES(NQ),
    .DST_OFFSET(DO),
    .FIFO_DEPTH_LOG2(FL),
    .DROP_NO_DST(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tvalid(tvalid),
    .tready(tready),
    .tdata(tdata),
    .tstrb(tstrb),
    .tuser(tuser),
    .tlast(tlast),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_rd(dout_rd),
    .oq(oq),
    .pkt_len(pkt_len),
    .pkt_len_valid(pkt_len_valid),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [TB-1:0] strb;
    logic [NQ-1:0] dst;
    logic          last;
    logic          keep;
    logic          drop_sop;
    logic [WW-1:0] word;
    logic          has_len;
    logic [15:0]   len;
  } beat_t;

  typedef struct {
    logic [WW-1:0] word;
    logic [NQ-1:0] dst;
  } exp_t;

  typedef struct {
    logic [TB-1:0] strb;
    int            cnt;
  } vec_t;

  beat_t         bq[$];
  exp_t          expq[$];
  logic [15:0]   lenq[$];
  logic [TB-1:0] sq[$];
  vec_t          tbl[6];

  int nvec = 0;
  int nerr = 0;
  int exp_drops = 0;
  int rd_mode = 1;
  int accepted = 0;
  int stalls = 0;
  int pulses = 0;

  task automatic chk(input string nm, input logic [WW-1:0] act,
                     input logic [WW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [TB-1:0] rnd_strb();
    logic [TB-1:0] s;
    case ($urandom % 4)
      0: s = '1;
      1: s = '0;
      default: s = TB'($urandom);
    endcase
    return s;
  endfunction

  // Turn the strobes in sq into one packet's beats and expected words
  task automatic add_pkt(input logic [NQ-1:0] dst, input int ovr);
    int n;
    int sum;
    beat_t b;
    logic [CW-1:0] c;
    n = sq.size();
    sum = 0;
    for (int i = 0; i < n; i++) begin
      b.strb = sq[i];
      b.data = rnd_data();
      b.dst  = dst;
      b.last = (i == n - 1);
      c = (ovr >= 0) ? CW'(ovr) : CW'($countones(sq[i]));
      sum = sum + int'(c);
      if (sum > 65535) sum = 65535;
      b.keep     = (dst != '0);
      b.drop_sop = (dst == '0) && (i == 0);
      b.word     = {b.last, logic'(i == 0), c, b.data};
      b.has_len  = b.keep && b.last;
      b.len      = 16'(sum);
      bq.push_back(b);
    end
    sq.delete();
  endtask

  // One clock: drive, check outputs, update the model, advance
  task automatic cycle();
    beat_t b;
    exp_t e;
    @(negedge clk);
    if (bq.size() > 0) begin
      tvalid = 1'b1;
      tdata  = bq[0].data;
      tstrb  = bq[0].strb;
      tuser  = '0;
      tuser[DO +: NQ] = bq[0].dst;
      tlast  = bq[0].last;
    end else begin
      tvalid = 1'b0;
    end
    if (rd_mode == 0) dout_rd = 1'b0;
    else if (rd_mode == 1) dout_rd = 1'b1;
    else dout_rd = logic'($urandom % 2);
    #1;
    if (dout_valid) begin
      if (expq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL spurious_word: got %h want none", dout);
      end else begin
        e = expq[0];
        chk("dout", dout, e.word);
        chk("oq", WW'(oq), WW'(e.dst));
        if (dout_rd) void'(expq.pop_front());
      end
    end else begin
      chk("oq_idle", WW'(oq), '0);
    end
    if (pkt_len_valid) begin
      pulses++;
      if (lenq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL spurious_len: got %0d want none", pkt_len);
      end else begin
        chk("pkt_len", WW'(pkt_len), WW'(lenq.pop_front()));
      end
    end
    if (tvalid && !tready) stalls++;
    if (tvalid && tready) begin
      b = bq.pop_front();
      accepted++;
      if (b.keep) begin
        e.word = b.word;
        e.dst  = b.dst;
        expq.push_back(e);
      end
      if (b.has_len) lenq.push_back(b.len);
      if (b.drop_sop) exp_drops++;
    end
    @(posedge clk);
  endtask

  task automatic run_all(input int limit, output int used);
    used = 0;
    while (bq.size() > 0 && used < limit) begin
      cycle();
      used++;
    end
    if (bq.size() > 0) begin
      nvec++;
      nerr++;
      $display("FAIL run_timeout: %0d beats left want 0", bq.size());
      bq.delete();
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    rd_mode = 1;
    while ((expq.size() > 0 || lenq.size() > 0) && n < limit) begin
      cycle();
      n++;
    end
    cycle();
    cycle();
    chk("drain_left", WW'(expq.size() + lenq.size()), '0);
    chk("drain_valid", WW'(dout_valid), '0);
    expq.delete();
    lenq.delete();
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    reset = 1'b1;
    tvalid = 1'b0;
    #1;
    chk("rst_dout_valid", WW'(dout_valid), '0);
    chk("rst_dout", dout, '0);
    chk("rst_oq", WW'(oq), '0);
    chk("rst_pkt_len", WW'(pkt_len), '0);
    chk("rst_len_valid", WW'(pkt_len_valid), '0);
    chk("rst_drop_cnt", WW'(drop_cnt), '0);
    chk("rst_tready", WW'(tready), '0);
    bq.delete();
    expq.delete();
    lenq.delete();
    exp_drops = 0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("tready_after_rst", WW'(tready), WW'(1));
  endtask

  initial begin
    int used;
    int p0;
    reset   = 1'b1;
    tvalid  = 1'b0;
    tdata   = '0;
    tstrb   = '0;
    tuser   = '0;
    tlast   = 1'b0;
    dout_rd = 1'b0;
    do_reset(2);

    // byte_cnt table, one single-beat packet per entry
    tbl[0].strb = '1;            tbl[0].cnt = 32;
    tbl[1].strb = '0;            tbl[1].cnt = 0;
    tbl[2].strb = 32'h0001_0001; tbl[2].cnt = 2;
    tbl[3].strb = 32'h0000_00FF; tbl[3].cnt = 8;
    tbl[4].strb = 32'h8000_0000; tbl[4].cnt = 1;
    tbl[5].strb = 32'hAAAA_5555; tbl[5].cnt = 16;
    for (int i = 0; i < 6; i++) begin
      sq.push_back(tbl[i].strb);
      add_pkt(NQ'(i + 1), tbl[i].cnt);
    end
    rd_mode = 2;
    run_all(200, used);
    drain(200);

    // three-beat packet to queue 2, 72 bytes
    p0 = pulses;
    sq.push_back('1);
    sq.push_back('1);
    sq.push_back(32'h0000_00FF);
    add_pkt(5'b00100, -1);
    rd_mode = 0;
    run_all(20, used);
    cycle();
    chk("oq_head_3beat", WW'(oq), WW'(5'b00100));
    chk("valid_3beat", WW'(dout_valid), WW'(1));
    drain(50);
    chk("pulses_3beat", WW'(pulses - p0), WW'(1));
    chk("pkt_len_3beat", WW'(pkt_len), WW'(72));

    // dropped 4-beat packet then a 1-beat packet to queue 0
    stalls = 0;
    for (int i = 0; i < 4; i++) sq.push_back('1);
    add_pkt('0, -1);
    sq.push_back(32'h0000_000F);
    add_pkt(5'b00001, -1);
    rd_mode = 1;
    run_all(20, used);
    drain(50);
    chk("drop_cnt_one", WW'(drop_cnt), WW'(1));
    chk("drop_stalls", WW'(stalls), '0);

    // FIFO fill to 16 with reads held off, then one read
    for (int i = 0; i < 20; i++) begin
      sq.push_back(rnd_strb());
      add_pkt(5'b00010, -1);
    end
    rd_mode = 0;
    accepted = 0;
    repeat (25) cycle();
    chk("fill_accepted", WW'(accepted), WW'(16));
    chk("full_tready", WW'(tready), '0);
    rd_mode = 1;
    cycle();
    rd_mode = 0;
    repeat (3) cycle();
    chk("one_more_accepted", WW'(accepted), WW'(17));
    chk("refull_tready", WW'(tready), '0);
    rd_mode = 1;
    run_all(100, used);
    drain(100);

    // reset in the middle of a 5-beat packet
    for (int i = 0; i < 5; i++) sq.push_back('1);
    add_pkt(5'b00011, -1);
    rd_mode = 0;
    cycle();
    cycle();
    do_reset(1);
    sq.push_back(32'h0000_FFFF);
    add_pkt(5'b00100, -1);
    rd_mode = 1;
    run_all(20, used);
    drain(50);

    // 100 back-to-back single-beat packets with reads always on
    for (int i = 0; i < 100; i++) begin
      sq.push_back(rnd_strb());
      add_pkt(NQ'($urandom_range(1, 31)), -1);
    end
    stalls = 0;
    rd_mode = 1;
    run_all(300, used);
    chk("stream_cycles", WW'(used), WW'(100));
    chk("stream_stalls", WW'(stalls), '0);
    drain(50);

    // random packets, random destinations and read pressure
    for (int p = 0; p < 40; p++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) sq.push_back(rnd_strb());
      if ($urandom % 4 == 0) add_pkt('0, -1);
      else add_pkt(NQ'($urandom_range(1, 31)), -1);
    end
    rd_mode = 2;
    run_all(3000, used);
    drain(200);
    chk("drop_cnt_rand", WW'(drop_cnt), WW'(16'(exp_drops)));

    // long packet: byte total saturates at 0xFFFF
    for (int i = 0; i < 2100; i++) sq.push_back('1);
    add_pkt(5'b10000, -1);
    rd_mode = 1;
    run_all(3000, used);
    drain(50);
    chk("pkt_len_sat", WW'(pkt_len), WW'(16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
